ext_pipe: RTL and testbench
===========================

// Module: ext_pipe
// PURPOSE
//  Parametrised, pipelined extension unit. Covers immediate zero/sign/lui extension and
//  load-data byte/halfword select-and-extend in one block. Elastic valid/ready pipeline
//  with flush; sits between the operand/DM-read path and the ALU/W-stage mux.
//  Counts illegal requests in a saturating error counter.
// PARAMETERS
//  DATA_W   32  data width; multiple of 16, >= 2*IMM_W
//  IMM_W    16  immediate width (low bits of in_data used by ZERO/SIGN/LUI)
//  LAT      1   pipeline stages, 1 or 2 (accept -> out_valid latency in cycles)
//  CNT_W    8   width of err_cnt
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               synchronous, active-high
//  flush      in   1               kill all in-flight entries
//  in_valid   in   1               request valid
//  in_ready   out  1               request accepted when in_valid & in_ready
//  in_mode    in   3               extension mode (below)
//  in_data    in   DATA_W          immediate (low IMM_W bits) or load word
//  in_off     in   log2(DATA_W/8)  byte offset for BYTE/HALF modes
//  out_valid  out  1               result valid
//  out_ready  in   1               consumer takes result when out_valid & out_ready
//  out_data   out  DATA_W          extended result
//  out_err    out  1               result came from an illegal request
//  err_cnt    out  CNT_W           saturating count of accepted illegal requests
// BEHAVIOUR
//  Clock: one clock, clk. Reset: synchronous, active-high, named reset.
//  Modes: 0 ZERO: {0, in_data[IMM_W-1:0]}; 1 SIGN: sign-extend in_data[IMM_W-1:0];
//   2 LUI: in_data[IMM_W-1:0] << (DATA_W-IMM_W), low bits 0;
//   3 BYTE_U/4 BYTE_S: byte in_data[8*off +: 8], zero/sign-extended;
//   5 HALF_U/6 HALF_S: half in_data[8*off +: 16], zero/sign-extended; requires off[0]==0;
//   7 reserved.
//  Illegal = mode 7, or HALF mode with off[0]==1, or any off selecting a half beyond
//   DATA_W. Illegal: data 0, err 1.
//  Extension is computed combinationally at the input and captured in stage 1; stage 2
//   (LAT=2) is a pure copy. out_* are driven directly from the last stage registers.
//  Elastic rule per stage: stage loads when empty or when its content leaves this cycle.
//   in_ready = ~s1_valid | s1_leaves. Combinational ready path from out_ready is allowed.
//   Full throughput: 1 result/cycle while out_ready held 1.
//  Stall: out_valid & ~out_ready -> all stages hold; out_data/out_err stable until taken.
//  Flush: next cycle all stage valids 0. A request accepted in the flush cycle is
//   dropped. in_ready may be 1 in the flush cycle. Flush does not change err_cnt.
//  err_cnt: +1 per accepted illegal request (in_valid & in_ready & illegal), including
//   one accepted in a flush cycle. Saturates at 2^CNT_W-1, no wrap.
//  Reset: all valids 0, out_valid 0, out_data 0, out_err 0, err_cnt 0, in_ready 1 the
//   cycle after reset deasserts. Reset mid-stream discards everything. reset overrides
//   flush.
//  Data registers need not clear on flush; out_data only matters when out_valid is 1.
// TESTING
//  T1 LAT=1, out_ready=1: SIGN 0x8001 -> next cycle out_data=0xFFFF8001;
//     ZERO 0x8001 -> 0x00008001; LUI 0x1234 -> 0x12340000; out_err=0.
//  T2 BYTE_S in_data=0x80FF7F01, off=0..3 -> 0x00000001, 0x0000007F,
//     0xFFFFFFFF, 0xFFFFFF80; BYTE_U off=2 -> 0x000000FF.
//  T3 HALF_S off=2 data=0x8000_1234 -> 0xFFFF8000; HALF_U off=1 -> out_err=1, data 0,
//     err_cnt=1; mode 7 -> err_cnt=2.
//  T4 LAT=2, back-to-back 4 requests, out_ready low for 3 cycles mid-stream -> no loss,
//     no duplication, order preserved; in_ready drops once both stages are full.
//  T5 flush with 2 entries in flight plus accept that cycle -> out_valid=0 next cycle;
//     the next accepted request emerges after LAT cycles; err_cnt unchanged by flush.
//  T6 CNT_W=2: 5 illegal requests -> err_cnt stays at 3; assert reset mid-stream ->
//     out_valid=0, err_cnt=0 next cycle.

Source files
------------

// File: rtl/ext_if.sv
// Request/result handshake bundle for the extension pipeline.
// The master issues requests and consumes results; the slave is the pipeline itself.
interface ext_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_data, in_off, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_off, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit behind an elastic valid/ready pipeline of
// LAT stages, with flush and a saturating illegal-request counter.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int LAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  ext_if.slave             bus,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  // Keep the low w bits of v; above them fill with zero, or with sb when sgn is set.
  function automatic logic [DATA_W-1:0] ext_field(input logic [DATA_W-1:0] v,
                                                  input int unsigned       w,
                                                  input logic              sgn,
                                                  input logic              sb);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = (i < w) ? v[i] : (sgn & sb);
    end
    return r;
  endfunction

  // Returns {illegal, result}; illegal requests produce a zero result.
  function automatic logic [DATA_W:0] ext_calc(input logic [2:0]        mode,
                                               input logic [DATA_W-1:0] d,
                                               input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    logic              bad;
    int unsigned       pos;
    sh  = d >> {off, 3'b000};
    pos = 32'(off) * 8;
    r   = '0;
    bad = 1'b0;
    case (mode)
      3'd0: r = ext_field(d, IMM_W, 1'b0, d[IMM_W-1]);
      3'd1: r = ext_field(d, IMM_W, 1'b1, d[IMM_W-1]);
      3'd2: r = {d[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};
      3'd3: r = ext_field(sh, 8, 1'b0, sh[7]);
      3'd4: r = ext_field(sh, 8, 1'b1, sh[7]);
      3'd5, 3'd6: begin
        bad = off[0] | ((pos + 16) > DATA_W);
        r   = ext_field(sh, 16, mode == 3'd6, sh[15]);
      end
      default: bad = 1'b1;
    endcase
    if (bad) r = '0;
    return {bad, r};
  endfunction

  logic [DATA_W:0]   res_c;
  logic              accept;
  logic              p1_leaves;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              err_p1;

  assign res_c        = ext_calc(bus.in_mode, bus.in_data, bus.in_off);
  assign bus.in_ready = ~vld_p1 | p1_leaves;
  assign accept       = bus.in_valid & bus.in_ready;

  // ---- input -> stage 1: extension result captured here ----
  always_ff @(posedge clk) begin
    if (reset)             vld_p1 <= 1'b0;
    else if (flush)        vld_p1 <= 1'b0;
    else if (bus.in_ready) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset && LAT == 1) begin
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (accept) begin
      data_p1 <= res_c[DATA_W-1:0];
      err_p1  <= res_c[DATA_W];
    end
  end

  // Requests accepted during a flush are dropped from the pipe but still counted.
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (accept && res_c[DATA_W] && !(&err_cnt))
      err_cnt <= err_cnt + 1'b1;
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic              vld_p2;
      logic [DATA_W-1:0] data_p2;
      logic              err_p2;
      logic              p2_load;

      assign p2_load   = ~vld_p2 | bus.out_ready;
      assign p1_leaves = vld_p1 & p2_load;

      // ---- stage 1 -> stage 2: pure copy ----
      always_ff @(posedge clk) begin
        if (reset)        vld_p2 <= 1'b0;
        else if (flush)   vld_p2 <= 1'b0;
        else if (p2_load) vld_p2 <= vld_p1;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          data_p2 <= '0;
          err_p2  <= 1'b0;
        end else if (p2_load && vld_p1) begin
          data_p2 <= data_p1;
          err_p2  <= err_p1;
        end
      end

      assign bus.out_valid = vld_p2;
      assign bus.out_data  = data_p2;
      assign bus.out_err   = err_p2;
    end else begin : g_lat1
      assign p1_leaves     = vld_p1 & bus.out_ready;
      assign bus.out_valid = vld_p1;
      assign bus.out_data  = data_p1;
      assign bus.out_err   = err_p1;
    end
  endgenerate
endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: three instances (LAT=1, LAT=2, LAT=1 with a 2-bit counter),
// directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ext_pipe;
  logic clk;
  logic reset;

  logic        iv[3];
  logic [2:0]  md[3];
  logic [31:0] dt[3];
  logic [1:0]  of[3];
  logic        ordy[3];
  logic        fl[3];
  logic        ird[3];
  logic        ov[3];
  logic        oerr[3];
  logic [31:0] od[3];
  logic [7:0]  ecnt[3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: mode rules evaluated with plain integer arithmetic. Returns {illegal, data}.
  function automatic logic [32:0] ref_ext(input logic [2:0] m, input logic [31:0] d,
                                          input logic [1:0] o);
    longint dv;
    longint v;
    longint ofs;
    dv  = longint'(d);
    ofs = longint'(o);
    v   = 0;
    case (m)
      3'd0: v = dv % 65536;
      3'd1: begin v = dv % 65536; if (v >= 32768) v = v - 65536; end
      3'd2: v = (dv % 65536) * 65536;
      3'd3, 3'd4: begin
        v = (dv / (longint'(1) << (8 * ofs))) % 256;
        if (m == 3'd4 && v >= 128) v = v - 256;
      end
      3'd5, 3'd6: begin
        if ((ofs % 2) == 1 || (8 * ofs + 16) > 32) return {1'b1, 32'h0};
        v = (dv / (longint'(1) << (8 * ofs))) % 65536;
        if (m == 3'd6 && v >= 32768) v = v - 65536;
      end
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, v[31:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L    = (g == 1) ? 2 : 1;
    localparam int CW   = (g == 2) ? 2 : 8;
    localparam int CMAX = (1 << CW) - 1;

    ext_if #(.DATA_W(32)) bus ();
    logic [CW-1:0] ec;

    assign bus.in_valid  = iv[g];
    assign bus.in_mode   = md[g];
    assign bus.in_data   = dt[g];
    assign bus.in_off    = of[g];
    assign bus.out_ready = ordy[g];
    assign ird[g]        = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign od[g]         = bus.out_data;
    assign oerr[g]       = bus.out_err;
    assign ecnt[g]       = 8'(ec);

    ext_pipe #(.DATA_W(32), .IMM_W(16), .LAT(L), .CNT_W(CW)) dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (fl[g]),
      .bus    (bus),
      .err_cnt(ec)
    );

    logic [32:0] q[$];
    logic [32:0] e;
    logic [32:0] prev_out;
    logic        prev_stall;
    logic        seen_rst;
    int          mcnt;
    int          qsz;
    int          nout;

    initial begin
      seen_rst   = 1'b0;
      prev_stall = 1'b0;
      mcnt       = 0;
      qsz        = 0;
      nout       = 0;
    end

    // Scoreboard: in-flight requests in accept order, killed by flush/reset.
    always @(negedge clk) begin
      if (seen_rst) begin
        chk($sformatf("d%0d_errcnt", g), 64'(ecnt[g]), 64'(mcnt));
        if (prev_stall)
          chk($sformatf("d%0d_hold", g), 64'({ov[g], oerr[g], od[g]}), 64'({1'b1, prev_out}));
        if (ov[g] && ordy[g]) begin
          if (q.size() == 0) begin
            chk($sformatf("d%0d_spurious", g), 64'(ov[g]), 64'(0));
          end else begin
            e = q.pop_front();
            chk($sformatf("d%0d_out", g), 64'({oerr[g], od[g]}), 64'(e));
            nout++;
          end
        end
        prev_stall = ov[g] && !ordy[g] && !reset && !fl[g];
        prev_out   = {oerr[g], od[g]};
        if (!reset && iv[g] && ird[g]) begin
          e = ref_ext(md[g], dt[g], of[g]);
          if (e[32] && mcnt < CMAX) mcnt++;
          if (!fl[g]) q.push_back(e);
        end
      end
      if (reset) begin
        q.delete();
        mcnt       = 0;
        prev_stall = 1'b0;
        seen_rst   = 1'b1;
      end else if (fl[g]) begin
        q.delete();
      end
      qsz = q.size();
    end
  end

  function automatic int get_qsz(input int i);
    case (i)
      0:       return lane[0].qsz;
      1:       return lane[1].qsz;
      default: return lane[2].qsz;
    endcase
  endfunction

  function automatic int get_nout(input int i);
    case (i)
      0:       return lane[0].nout;
      1:       return lane[1].nout;
      default: return lane[2].nout;
    endcase
  endfunction

  task automatic send(input int i, input logic [2:0] m, input logic [31:0] d, input logic [1:0] o);
    int w;
    @(posedge clk); #1;
    iv[i] = 1'b1; md[i] = m; dt[i] = d; of[i] = o;
    w = 0;
    @(negedge clk);
    while (!ird[i] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ird[i]) chk("accept_timeout", 64'(ird[i]), 64'(1));
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic expect_out(input int i, input int lat, input logic [31:0] ed, input logic ee,
                            input string tag);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk({tag, "_early"}, 64'(ov[i]), 64'(0));
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_v"}, 64'(ov[i]), 64'(1));
    chk({tag, "_d"}, 64'(od[i]), 64'(ed));
    chk({tag, "_e"}, 64'(oerr[i]), 64'(ee));
  endtask

  task automatic rnd(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      iv[i]   = ($urandom_range(3) != 0);
      md[i]   = 3'($urandom_range(7));
      dt[i]   = $urandom;
      of[i]   = 2'($urandom_range(3));
      ordy[i] = ($urandom_range(3) != 0);
      fl[i]   = ($urandom_range(19) == 0);
    end
    @(posedge clk); #1;
    iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk($sformatf("d%0d_drain_q", i), 64'(get_qsz(i)), 64'(0));
    chk($sformatf("d%0d_drain_v", i), 64'(ov[i]), 64'(0));
  endtask

  initial begin
    int k;
    int cyc;
    int nbase;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; md[i] = 3'd0; dt[i] = 32'h0; of[i] = 2'd0; ordy[i] = 1'b1; fl[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_v%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("rst_d%0d", i), 64'(od[i]), 64'(0));
      chk($sformatf("rst_e%0d", i), 64'(oerr[i]), 64'(0));
      chk($sformatf("rst_c%0d", i), 64'(ecnt[i]), 64'(0));
      chk($sformatf("rst_r%0d", i), 64'(ird[i]), 64'(1));
    end

    // T1..T3 on the LAT=1 instance
    send(0, 3'd1, 32'h0000_8001, 2'd0); expect_out(0, 1, 32'hFFFF_8001, 1'b0, "t1_sign");
    send(0, 3'd0, 32'h0000_8001, 2'd0); expect_out(0, 1, 32'h0000_8001, 1'b0, "t1_zero");
    send(0, 3'd2, 32'h0000_1234, 2'd0); expect_out(0, 1, 32'h1234_0000, 1'b0, "t1_lui");
    send(0, 3'd4, 32'h80FF_7F01, 2'd0); expect_out(0, 1, 32'h0000_0001, 1'b0, "t2_bs0");
    send(0, 3'd4, 32'h80FF_7F01, 2'd1); expect_out(0, 1, 32'h0000_007F, 1'b0, "t2_bs1");
    send(0, 3'd4, 32'h80FF_7F01, 2'd2); expect_out(0, 1, 32'hFFFF_FFFF, 1'b0, "t2_bs2");
    send(0, 3'd4, 32'h80FF_7F01, 2'd3); expect_out(0, 1, 32'hFFFF_FF80, 1'b0, "t2_bs3");
    send(0, 3'd3, 32'h80FF_7F01, 2'd2); expect_out(0, 1, 32'h0000_00FF, 1'b0, "t2_bu2");
    send(0, 3'd6, 32'h8000_1234, 2'd2); expect_out(0, 1, 32'hFFFF_8000, 1'b0, "t3_hs2");
    send(0, 3'd5, 32'h8000_1234, 2'd1); expect_out(0, 1, 32'h0000_0000, 1'b1, "t3_hu1");
    chk("t3_cnt1", 64'(ecnt[0]), 64'(1));
    send(0, 3'd7, 32'h1234_5678, 2'd0); expect_out(0, 1, 32'h0000_0000, 1'b1, "t3_m7");
    chk("t3_cnt2", 64'(ecnt[0]), 64'(2));

    // T4: LAT=2 back-to-back with a 3-cycle consumer stall
    nbase = get_nout(1);
    k = 0;
    cyc = 0;
    @(posedge clk); #1;
    while (k < 4 && cyc < 40) begin
      iv[1] = 1'b1; md[1] = 3'd1; dt[1] = $urandom; of[1] = 2'd0;
      ordy[1] = !(cyc >= 1 && cyc <= 3);
      @(negedge clk);
      if (cyc == 2) chk("t4_full_rdy", 64'(ird[1]), 64'(0));
      if (ird[1]) k++;
      @(posedge clk); #1;
      cyc++;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_count", 64'(get_nout(1) - nbase), 64'(4));
    chk("t4_left", 64'(get_qsz(1)), 64'(0));

    // T5: flush with two entries in flight and an illegal accept in the flush cycle
    @(posedge clk); #1;
    ordy[1] = 1'b0; iv[1] = 1'b1; md[1] = 3'd0; dt[1] = 32'h0000_0AAA; of[1] = 2'd0;
    @(posedge clk); #1;
    dt[1] = 32'h0000_0BBB;
    @(posedge clk); #1;
    fl[1] = 1'b1; ordy[1] = 1'b1; md[1] = 3'd7;
    @(negedge clk);
    chk("t5_rdy_in_flush", 64'(ird[1]), 64'(1));
    @(posedge clk); #1;
    fl[1] = 1'b0; iv[1] = 1'b0;
    @(negedge clk);
    chk("t5_v_after", 64'(ov[1]), 64'(0));
    chk("t5_cnt", 64'(ecnt[1]), 64'(1));
    send(1, 3'd0, 32'hFFFF_C0DE, 2'd0); expect_out(1, 2, 32'h0000_C0DE, 1'b0, "t5_next");

    // T6: 2-bit counter saturation, then reset in the middle of a stalled stream
    for (int n = 0; n < 5; n++) begin
      send(2, 3'd7, $urandom, 2'd0);
      expect_out(2, 1, 32'h0, 1'b1, "t6_ill");
    end
    chk("t6_sat", 64'(ecnt[2]), 64'(3));
    @(posedge clk); #1;
    ordy[2] = 1'b0; iv[2] = 1'b1; md[2] = 3'd0; dt[2] = $urandom; of[2] = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_busy", 64'(ov[2]), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; iv[2] = 1'b0; ordy[2] = 1'b1;
    @(negedge clk);
    chk("t6_rst_v", 64'(ov[2]), 64'(0));
    chk("t6_rst_cnt", 64'(ecnt[2]), 64'(0));
    chk("t6_rst_rdy", 64'(ird[2]), 64'(1));

    rnd(0, 600);
    rnd(1, 600);
    rnd(2, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
